vend_sequencer: RTL
===================

// Module: vend_sequencer
// PURPOSE
//  Sequencer in front of the 4-bit coffee-vending credit FSM (states S0..S400, codes 0..8).
//  Buffers coin events from the coin acceptor in a small FIFO.
//  Feeds coins to the FSM one at a time as single-cycle r50/r100/r200 pulses and captures its cafe/t50/t100 result.
//  Runs the drink dispenser (req/done handshake with timeout) and the change ejector (valid/ready, one coin per transfer).
// PARAMETERS
//  FIFO_DEPTH    4     coin FIFO entries; power of 2, >=2
//  BREW_TIMEOUT  1000  max cycles brew_req waits for brew_done; >=2
//  CNT_W         16    width of vend_count
// PORTS
//  clk         in   1      clock, all flops rising edge
//  rst_n       in   1      async active-low reset
//  coin_valid  in   1      coin event from acceptor
//  coin_code   in   2      01=50, 10=100, 11=200, 00=invalid
//  coin_ready  out  1      coin event accepted when coin_valid&&coin_ready
//  fsm_r50     out  1      to FSM r50
//  fsm_r100    out  1      to FSM r100
//  fsm_r200    out  1      to FSM r200
//  fsm_cafe    in   1      from FSM cafe
//  fsm_t50     in   1      from FSM t50
//  fsm_t100    in   1      from FSM t100
//  fsm_state   in   4      FSM current state code
//  brew_req    out  1      dispense-drink request, level
//  brew_done   in   1      dispenser completion, 1-cycle pulse
//  chg_valid   out  1      change coin pending
//  chg_code    out  2      01=50, 10=100 (never 11/00 while chg_valid)
//  chg_ready   in   1      ejector took coin
//  busy        out  1      state != IDLE or FIFO non-empty
//  fault       out  1      sticky brew timeout flag
//  vend_count  out  CNT_W  completed brews, wraps to 0
// BEHAVIOUR
//  Reset: all outputs 0 except coin_ready=1. FIFO empty, state IDLE, fault=0, vend_count=0.
//  Reset mid-operation aborts the current transfer; no pulse completes. The FSM is reset from the same source.
//  FIFO and coin_ready:
//   - coin_ready = !full && !fault, computed from registered state; a same-cycle pop does not free space.
//   - code 00 is handshaked but never written.
//  States:
//   - IDLE: if FIFO non-empty and fsm_state<=4, pop head into cur_code and go to FEED. Otherwise stay.
//   - FEED (1 cycle): assert exactly one of fsm_r50/r100/r200 per cur_code (only in FEED); go to SETTLE.
//   - SETTLE (1 cycle): sample fsm_cafe/t50/t100 into chg100_p/chg50_p.
//     If fsm_cafe=1: go to BREW and clear the timer. Else go to IDLE.
//   - BREW: brew_req=1.
//     On brew_done: brew_req drops next cycle, vend_count+1, go to EJECT.
//     If the timer reaches BREW_TIMEOUT first: fault<=1, go to EJECT with no count increment.
//     brew_done outside BREW is ignored.
//   - EJECT: if chg100_p, present chg_code=10 first; then if chg50_p, present chg_code=01.
//     chg_valid/chg_code stay stable until chg_ready. Each handshake clears its pending bit.
//     Go to IDLE when both bits are clear; with no change owed, go to IDLE in 1 cycle.
//  Latency: coin accepted at edge k -> pop at edge k+1 -> r* high in cycle k+1..k+2 -> brew_req high from edge k+3 when it vends.
//  Coins arriving during BREW/EJECT queue in the FIFO. Popping resumes only in IDLE.
//  fsm_state>4 in IDLE (vend still settling): wait, no pop.
//  Fault is sticky until rst_n. While fault=1: coin_ready=0, but FIFO contents still drain.
// TESTING
//  1. Reset, coins 100,100,50 back-to-back -> r100,r100,r50 pulses 3 cycles apart; brew_req rises; brew_done -> vend_count=1, no chg_valid.
//  2. Coins 200,200 -> after 2nd SETTLE, brew; then chg_code=10 then 01 (ready held 1) -> 2 handshakes, return to IDLE.
//  3. chg_ready=0 for 5 cycles in EJECT -> chg_valid/chg_code held at 10 unchanged; proceeds on first ready.
//  4. Fill FIFO with 4 coins while brew_done withheld -> coin_ready=0; 5th coin is not accepted; FIFO drains after brew_done.
//  5. brew_done never arrives -> fault=1 after exactly BREW_TIMEOUT cycles, vend_count unchanged, change still ejected, coin_ready=0.
//  6. rst_n low during BREW with 2 coins queued -> all outputs reset values, FIFO empty, no further r* pulses.

Source files
------------

// File: rtl/vend_sequencer.sv
// vend_sequencer: queues coin events, feeds them to the coffee credit FSM, and runs the brew and change handshakes
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   coin_valid/coin_code/coin_ready   coin acceptor handshake (01=50, 10=100, 11=200, 00 dropped)
//   fsm_r50/fsm_r100/fsm_r200   one-cycle coin pulses to the credit FSM
//   fsm_cafe/fsm_t50/fsm_t100/fsm_state   credit FSM result and current state code
//   brew_req/brew_done          dispenser request level / completion pulse
//   chg_valid/chg_code/chg_ready   change ejector handshake, one coin per transfer
//   busy, fault, vend_count     status: activity, sticky brew timeout, completed brews
module vend_sequencer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BREW_TIMEOUT = 1000,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_valid,
    input  logic [1:0]       coin_code,
    output logic             coin_ready,
    output logic             fsm_r50,
    output logic             fsm_r100,
    output logic             fsm_r200,
    input  logic             fsm_cafe,
    input  logic             fsm_t50,
    input  logic             fsm_t100,
    input  logic [3:0]       fsm_state,
    output logic             brew_req,
    input  logic             brew_done,
    output logic             chg_valid,
    output logic [1:0]       chg_code,
    input  logic             chg_ready,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] vend_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(BREW_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FEED, SETTLE, BREW, EJECT} state_t;

    state_t        state;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic [TW-1:0] timer;
    logic          chg100_p, chg50_p;
    logic          full, push, pop;

    // Space is judged on registered occupancy only, so a pop in the same cycle never frees a slot early.
    assign full       = cnt == (AW+1)'(FIFO_DEPTH);
    assign coin_ready = !full && !fault;
    assign push       = coin_valid && coin_ready && coin_code != 2'b00;
    // A credit FSM above S200 is still finishing a vend, so hold the next coin back.
    assign pop        = state == IDLE && cnt != '0 && fsm_state <= 4'd4;
    assign busy       = state != IDLE || cnt != '0;

    always_ff @(posedge clk)
        if (push) mem[wp] <= coin_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            timer      <= '0;
            chg100_p   <= 1'b0;
            chg50_p    <= 1'b0;
            fsm_r50    <= 1'b0;
            fsm_r100   <= 1'b0;
            fsm_r200   <= 1'b0;
            brew_req   <= 1'b0;
            chg_valid  <= 1'b0;
            chg_code   <= 2'b00;
            fault      <= 1'b0;
            vend_count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt      <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            fsm_r50  <= 1'b0;
            fsm_r100 <= 1'b0;
            fsm_r200 <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    fsm_r50  <= mem[rp] == 2'b01;
                    fsm_r100 <= mem[rp] == 2'b10;
                    fsm_r200 <= mem[rp] == 2'b11;
                    state    <= FEED;
                end
                FEED: state <= SETTLE;
                SETTLE: begin
                    chg100_p <= fsm_t100;
                    chg50_p  <= fsm_t50;
                    timer    <= '0;
                    brew_req <= fsm_cafe;
                    state    <= fsm_cafe ? BREW : IDLE;
                end
                BREW: if (brew_done || timer == TW'(BREW_TIMEOUT - 1)) begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (brew_done) vend_count <= vend_count + 1'b1;
                    else fault <= 1'b1;
                    brew_req  <= 1'b0;
                    chg_valid <= chg100_p || chg50_p;
                    chg_code  <= chg100_p ? 2'b10 : chg50_p ? 2'b01 : 2'b00;
                    state     <= EJECT;
                end else begin
                    timer <= timer + 1'b1;
                end
                EJECT: if (!chg_valid) begin
                    state <= IDLE;
                end else if (chg_ready) begin
                    if (chg_code == 2'b10) chg100_p <= 1'b0;
                    else chg50_p <= 1'b0;
                    if (chg_code == 2'b10 && chg50_p) begin
                        chg_code <= 2'b01;
                    end else begin
                        chg_valid <= 1'b0;
                        chg_code  <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
